// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and line constants for the FIFO-drain UART transmitter.
package fifo_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int   DEFAULT_CLKS_PER_BIT = 434;
   localparam logic IDLE_LVL             = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..clks_per_bit-1 and flags the terminal count for one cycle.
// Synchronous clear restarts the bit period; no backpressure, free-running otherwise.
module baud_tick #(
   parameter int clks_per_bit = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   localparam logic [CW-1:0] TC = CW'(clks_per_bit - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || (cnt_q == TC)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == TC);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls one byte per frame from the FIFO read port and sends it as 8N1 (8E1 with FIFO_UART_TX_PARITY_EN).
// Read-to-start-bit latency 3 cycles; FIFO flags are only looked at in IDLE, so a frame never stalls.
module fifo_uart_tx
   import fifo_tx_pkg::*;
#(
   parameter int dato_width   = 8,
   parameter int clks_per_bit = DEFAULT_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  empy,
   input  logic                  dato,
   input  logic [dato_width-1:0] datin,
   output logic                  rd,
   output logic                  tx,
   output logic                  busy,
   output logic                  sent
);

   localparam int            BW   = (dato_width > 1) ? $clog2(dato_width) : 1;
   localparam logic [BW-1:0] LAST = BW'(dato_width - 1);

   state_t                  state_q, state_d;
   logic                    rd_q, rd_d;
   logic                    tx_q, tx_d;
   logic [dato_width-1:0]   shift_q, shift_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [BW-1:0]           bit_nxt;
   logic                    tick;
   logic                    clr;

   // Every state change restarts the bit period so each state gets a full bit time.
   assign clr = (state_d != state_q);

   baud_tick #(
      .clks_per_bit(clks_per_bit)
   ) u_baud (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .tick(tick)
   );

   assign bit_nxt = bit_q + 1'b1;

   always_comb begin
      state_d = state_q;
      rd_d    = 1'b0;
      tx_d    = tx_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      case (state_q)
         IDLE: begin
            tx_d  = IDLE_LVL;
            bit_d = '0;
            if (en && dato && !empy) begin
               state_d = READ;
               rd_d    = 1'b1;
            end
         end
         READ: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Registered FIFO output has settled one edge after the read strobe.
            shift_d = datin;
            tx_d    = 1'b0;
            state_d = START;
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_q == LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^shift_q;
`else
                  state_d = STOP;
                  tx_d    = IDLE_LVL;
`endif
               end else begin
                  bit_d = bit_nxt;
                  tx_d  = shift_q[bit_nxt];
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               tx_d    = IDLE_LVL;
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LVL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         tx_q    <= IDLE_LVL;
         shift_q <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         tx_q    <= tx_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
      end
   end

   assign rd   = rd_q;
   assign tx   = tx_q;
   assign busy = (state_q != IDLE);
   assign sent = (state_q == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised scoreboard bench for fifo_uart_tx with a registered-output FIFO model and a line decoder.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
   localparam int W   = 8;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       en    = 1'b0;
   logic       empy  = 1'b1;
   logic       dato  = 1'b0;
   logic [7:0] datin = 8'h00;
   logic       rd, tx, busy, sent;

   int chk = 0;
   int err = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] push_q[$];
   logic [7:0] exp_q[$];
   int         gap_q[$];

   int         rd_cnt      = 0;
   int         frames_done = 0;
   int         n_push      = 0;
   logic       in_frame    = 1'b0;
   int         cyc         = 0;
   int         idle_cnt    = 0;
   logic       rd_prev     = 1'b0;
   logic [7:0] cur         = 8'h00;

   fifo_uart_tx #(
      .dato_width  (W),
      .clks_per_bit(CPB)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .empy (empy),
      .dato (dato),
      .datin(datin),
      .rd   (rd),
      .tx   (tx),
      .busy (busy),
      .sent (sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected line level for bit slot idx of a frame carrying byte b.
   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= W) return b[idx-1];
      if (idx == NB - 1) return 1'b1;
      return ^b;
   endfunction

   task automatic push(input logic [7:0] b);
      push_q.push_back(b);
      exp_q.push_back(b);
      n_push++;
   endtask

   task automatic wait_frames(input int n);
      int t;
      t = 0;
      while (frames_done < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("frame_timeout", (frames_done >= n), 1'b1);
   endtask

   // FIFO model: registered datout, flags updated on the clock edge.
   always @(posedge clk) begin
      if (rd) begin
         check("rd_while_empty", (fifo_q.size() == 0), 1'b0);
         if (fifo_q.size() != 0) datin <= fifo_q.pop_front();
      end
      while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
      empy <= (fifo_q.size() == 0);
      dato <= (fifo_q.size() != 0);
   end

   // Line monitor: decodes frames and compares every cycle against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         check("reset_tx", tx, 1'b1);
         check("reset_rd", rd, 1'b0);
         check("reset_busy", busy, 1'b0);
         check("reset_sent", sent, 1'b0);
         in_frame = 1'b0;
         idle_cnt = 0;
         rd_prev  = 1'b0;
      end else begin
         if (rd) begin
            rd_cnt++;
            check("rd_single_cycle", rd_prev, 1'b0);
         end
         rd_prev = rd;
         if (!in_frame) begin
            if (tx == 1'b0) begin
               check("frame_expected", (exp_q.size() != 0), 1'b1);
               cur = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
               gap_q.push_back(idle_cnt);
               in_frame = 1'b1;
               cyc      = 0;
               check("busy_start", busy, 1'b1);
               check("sent_start", sent, 1'b0);
            end else begin
               idle_cnt++;
               check("sent_idle", sent, 1'b0);
            end
         end else begin
            cyc++;
            check("tx_bit", tx, exp_bit(cur, cyc / CPB));
            check("busy_frame", busy, 1'b1);
            check("sent_pulse", sent, (cyc == FRAME - 1));
            if (cyc == FRAME - 1) begin
               in_frame = 1'b0;
               frames_done++;
               idle_cnt = 0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nf;
      int base;
      int t;
      nf = 0;

      // Reset hold with data waiting, then 0xA5 frame.
      en = 1'b1;
      push(8'hA5);
      repeat (5) @(negedge clk);
      check("empy_during_reset", empy, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("rd_after_release", rd, 1'b1);
      nf++;
      wait_frames(nf);
      @(negedge clk);
      check("rd_count_a5", rd_cnt, 1);
      check("busy_after_a5", busy, 1'b0);

      // Back-to-back 0x00, 0xFF.
      repeat (4) @(negedge clk);
      #1;
      gap_q.delete();
      base = rd_cnt;
      push(8'h00);
      push(8'hFF);
      nf += 2;
      wait_frames(nf);
      @(negedge clk);
      check("rd_count_b2b", rd_cnt - base, 2);
      check("gap_count", gap_q.size(), 2);
      if (gap_q.size() >= 2) check("interframe_gap", gap_q[1], 3);

      // FIFO empties after the read of 0x3C.
      base = rd_cnt;
      push(8'h3C);
      nf++;
      wait_frames(nf);
      repeat (20) @(negedge clk);
      check("rd_count_3c", rd_cnt - base, 1);
      check("empy_after_3c", empy, 1'b1);

      // Reset during DATA bit 3 of 0x5A.
      push(8'h5A);
      t = 0;
      while (!(in_frame && cyc >= 4 * CPB + 1) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("reach_data_bit3", (in_frame && cyc >= 4 * CPB + 1 && cyc < 5 * CPB), 1'b1);
      #1;
      rst = 1'b0;
      #1;
      check("async_tx_high", tx, 1'b1);
      check("async_busy_low", busy, 1'b0);
      repeat (2) @(negedge clk);
      push(8'h11);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rd_after_mid_reset", rd, 1'b1);
      nf++;
      wait_frames(nf);

      // Enable gating.
      repeat (4) @(negedge clk);
      en = 1'b0;
      push(8'h77);
      base = rd_cnt;
      repeat (20) @(negedge clk);
      check("no_rd_when_disabled", rd_cnt - base, 0);
      en = 1'b1;
      @(negedge clk);
      check("rd_after_enable", rd, 1'b1);
      nf++;
      wait_frames(nf);

      // Randomised traffic with enable toggling.
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 50)) @(negedge clk);
         en = ($urandom_range(0, 3) != 0);
         push(8'($urandom));
         nf++;
      end
      @(negedge clk);
      en = 1'b1;
      wait_frames(nf);
      repeat (6) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("rd_total", rd_cnt, n_push);
      check("final_busy", busy, 1'b0);
      check("final_tx", tx, 1'b1);
      check("final_empy", empy, 1'b1);

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
